// File: rtl/sdr_modport_checker.sv
`default_nettype none
// ============================================================================
// Module   : sdr_modport_checker
// Summary  : Passive SDRAM command-bus monitor with a legality FSM per bank;
//            tRAS/tRCD checks are built when SDR_MON_TIMING_EN is defined.
// Revision : 1.0
// ============================================================================
module sdr_modport_checker #(
  parameter int BURST_LENGTH = 1,
  parameter int TRAS         = 1,
  parameter int TRCD         = 1,
  parameter int TRP          = 1,
  parameter int CNT_W        = 16
) (
  input  logic             sdram_clk,
  input  logic             sdram_reset,
  input  logic             sdr_init_done,
  input  logic             sdr_cs_n,
  input  logic             sdr_ras_n,
  input  logic             sdr_cas_n,
  input  logic             sdr_we_n,
  input  logic [1:0]       sdr_ba,
  input  logic [12:0]      sdr_addr,
  output logic [15:0]      bank_state,
  output logic [3:0]       cmd_err,
  output logic [1:0]       timing_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] C_CMD_LMR  = 3'b000;
  localparam logic [2:0] C_CMD_AREF = 3'b001;
  localparam logic [2:0] C_CMD_PRE  = 3'b010;
  localparam logic [2:0] C_CMD_ACT  = 3'b011;
  localparam logic [2:0] C_CMD_WR   = 3'b100;
  localparam logic [2:0] C_CMD_RD   = 3'b101;
  localparam logic [2:0] C_CMD_BST  = 3'b110;
  localparam logic [2:0] C_CMD_NOP  = 3'b111;

  localparam logic [3:0] C_ST_INIT        = 4'd0;
  localparam logic [3:0] C_ST_IDLE        = 4'd1;
  localparam logic [3:0] C_ST_REFRESH     = 4'd2;
  localparam logic [3:0] C_ST_ACTIVATING  = 4'd3;
  localparam logic [3:0] C_ST_ACTIVE      = 4'd4;
  localparam logic [3:0] C_ST_RD          = 4'd5;
  localparam logic [3:0] C_ST_RD_AP       = 4'd6;
  localparam logic [3:0] C_ST_WR          = 4'd7;
  localparam logic [3:0] C_ST_WR_AP       = 4'd8;
  localparam logic [3:0] C_ST_PRECHARGING = 4'd9;

  // Dwell counters only need to reach the largest exit threshold.
  localparam int C_MAX_A = (BURST_LENGTH > TRCD) ? BURST_LENGTH : TRCD;
  localparam int C_MAX_T = (C_MAX_A > TRP) ? C_MAX_A : TRP;
  localparam int C_CW    = $clog2(C_MAX_T + 1) + 1;

  localparam logic [C_CW-1:0] C_BL_M1   = C_CW'((BURST_LENGTH > 1) ? BURST_LENGTH - 1 : 0);
  localparam logic [C_CW-1:0] C_TRCD_M1 = C_CW'((TRCD > 1) ? TRCD - 1 : 0);
  localparam logic [C_CW-1:0] C_TRP_M1  = C_CW'((TRP > 1) ? TRP - 1 : 0);

  logic [2:0]       w_cmd;
  logic [3:0]       w_tgt;
  logic             w_unused_addr;
  logic [2:0]       w_err_add;
  logic [CNT_W:0]   w_err_sum;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_cmd         = sdr_cs_n ? C_CMD_NOP : {sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign w_unused_addr = ^{sdr_addr[12:11], sdr_addr[9:0]};

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [C_CW-1:0] r_cnt;
    logic            r_cmd_err;
    logic            w_illegal;
    logic            w_rw;
    logic            w_cnt_clr;

    assign w_tgt[b]  = (sdr_ba == 2'(b)) || ((w_cmd == C_CMD_PRE) && sdr_addr[10]);
    assign w_rw      = w_tgt[b] && ((w_cmd == C_CMD_RD) || (w_cmd == C_CMD_WR));
    // A READ/WRITE accepted inside a burst restarts the burst timer.
    assign w_cnt_clr = (w_next != r_state) ||
                       (w_rw && ((r_state == C_ST_RD) || (r_state == C_ST_WR)));

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
        r_state   <= C_ST_INIT;
        r_cnt     <= '0;
        r_cmd_err <= 1'b0;
      end else begin
        r_state   <= w_next;
        r_cmd_err <= w_illegal;
        if (w_cnt_clr) begin
          r_cnt <= '0;
        end else if (r_cnt != '1) begin
          r_cnt <= r_cnt + C_CW'(1);
        end
      end
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        C_ST_INIT: begin
          if (sdr_init_done) w_next = C_ST_IDLE;
        end
        C_ST_IDLE: begin
          if (w_tgt[b] && (w_cmd == C_CMD_ACT))       w_next = C_ST_ACTIVATING;
          else if (w_tgt[b] && (w_cmd == C_CMD_AREF)) w_next = C_ST_REFRESH;
        end
        C_ST_REFRESH: w_next = C_ST_IDLE;
        C_ST_ACTIVATING: begin
          if (r_cnt >= C_TRCD_M1) w_next = C_ST_ACTIVE;
        end
        C_ST_ACTIVE: begin
          if (w_tgt[b]) begin
            case (w_cmd)
              C_CMD_WR:  w_next = sdr_addr[10] ? C_ST_WR_AP : C_ST_WR;
              C_CMD_RD:  w_next = sdr_addr[10] ? C_ST_RD_AP : C_ST_RD;
              C_CMD_PRE: w_next = C_ST_PRECHARGING;
              default:   w_next = r_state;
            endcase
          end
        end
        C_ST_RD, C_ST_WR: begin
          if (w_tgt[b] && (w_cmd == C_CMD_WR))       w_next = C_ST_WR;
          else if (w_tgt[b] && (w_cmd == C_CMD_RD))  w_next = C_ST_RD;
          else if (w_tgt[b] && (w_cmd == C_CMD_PRE)) w_next = C_ST_PRECHARGING;
          else if (w_tgt[b] && (w_cmd == C_CMD_BST)) w_next = C_ST_ACTIVE;
          else if (r_cnt >= C_BL_M1)                 w_next = C_ST_ACTIVE;
        end
        C_ST_RD_AP, C_ST_WR_AP: begin
          if (r_cnt >= C_BL_M1) w_next = C_ST_PRECHARGING;
        end
        C_ST_PRECHARGING: begin
          if (r_cnt >= C_TRP_M1) w_next = C_ST_IDLE;
        end
        default: w_next = C_ST_INIT;
      endcase
    end

    always_comb begin
      w_illegal = 1'b0;
      if (w_tgt[b] && (w_cmd != C_CMD_NOP)) begin
        case (r_state)
          C_ST_INIT:        w_illegal = 1'b0;
          C_ST_IDLE:        w_illegal = !(w_cmd inside {C_CMD_ACT, C_CMD_AREF, C_CMD_LMR, C_CMD_PRE});
          C_ST_ACTIVE:      w_illegal = !(w_cmd inside {C_CMD_RD, C_CMD_WR, C_CMD_PRE});
          C_ST_RD, C_ST_WR: w_illegal = !(w_cmd inside {C_CMD_RD, C_CMD_WR, C_CMD_PRE, C_CMD_BST});
          default:          w_illegal = 1'b1;
        endcase
      end
    end

    assign bank_state[4*b +: 4] = r_state;
    assign cmd_err[b]           = r_cmd_err;
  end

`ifdef SDR_MON_TIMING_EN
  localparam int C_AGE_MAX = (TRAS > TRCD) ? TRAS : TRCD;
  localparam int C_AW      = $clog2(C_AGE_MAX + 1) + 1;

  localparam logic [C_AW-1:0] C_AGE_SAT = C_AW'(C_AGE_MAX);
  localparam logic [C_AW-1:0] C_TRAS_A  = C_AW'(TRAS);
  localparam logic [C_AW-1:0] C_TRCD_A  = C_AW'(TRCD);

  logic [3:0] w_tras_viol;
  logic [3:0] w_trcd_viol;
  logic [1:0] r_timing_err;

  for (genvar b = 0; b < 4; b++) begin : g_age
    logic [C_AW-1:0] r_age;
    logic            r_age_vld;

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
      if (sdram_reset) begin
        r_age     <= '0;
        r_age_vld <= 1'b0;
      end else if ((w_cmd == C_CMD_ACT) && (sdr_ba == 2'(b))) begin
        r_age     <= '0;
        r_age_vld <= 1'b1;
      end else if (r_age != C_AGE_SAT) begin
        r_age <= r_age + C_AW'(1);
      end
    end

    assign w_tras_viol[b] = r_age_vld && w_tgt[b] && (w_cmd == C_CMD_PRE) && (r_age < C_TRAS_A);
    assign w_trcd_viol[b] = r_age_vld && w_tgt[b] &&
                            ((w_cmd == C_CMD_RD) || (w_cmd == C_CMD_WR)) && (r_age < C_TRCD_A);
  end

  always_ff @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset) r_timing_err <= 2'b00;
    else             r_timing_err <= {|w_trcd_viol, |w_tras_viol};
  end

  assign timing_err = r_timing_err;
`else
  assign timing_err = 2'b00;
`endif

  assign w_err_add = 3'(cmd_err[0]) + 3'(cmd_err[1]) + 3'(cmd_err[2]) + 3'(cmd_err[3]) +
                     3'(timing_err[0]) + 3'(timing_err[1]);
  assign w_err_sum = {1'b0, r_err_cnt} + (CNT_W+1)'(w_err_add);

  always_ff @(posedge sdram_clk or posedge sdram_reset) begin
    if (sdram_reset)          r_err_cnt <= '0;
    else if (w_err_sum[CNT_W]) r_err_cnt <= '1;
    else                      r_err_cnt <= w_err_sum[CNT_W-1:0];
  end

  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdr_modport_checker.sv
`default_nettype none
// tb_sdr_modport_checker: directed literal sequences plus random command traffic
// compared every cycle against a bank-level behavioural model.
module tb_sdr_modport_checker;

  localparam int BL      = 4;
  localparam int TRAS    = 5;
  localparam int TRCD    = 2;
  localparam int TRP     = 3;
  localparam int AGE_MAX = (TRAS > TRCD) ? TRAS : TRCD;
`ifdef SDR_MON_TIMING_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  localparam int S_INIT = 0, S_IDLE = 1, S_REFRESH = 2, S_ACTIVATING = 3, S_ACTIVE = 4;
  localparam int S_RD = 5, S_RD_AP = 6, S_WR = 7, S_WR_AP = 8, S_PRECHARGING = 9;

  typedef enum logic [2:0] {LMR = 3'd0, AREF = 3'd1, PRE = 3'd2, ACT = 3'd3,
                            WRITE = 3'd4, READ = 3'd5, BST = 3'd6, NOP = 3'd7} cmd_t;

  logic        clk = 1'b0, rst = 1'b1, init_done = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = 2'd0;
  logic [12:0] addr = 13'd0;
  logic [15:0] bank_state, bank_state_s;
  logic [3:0]  cmd_err, cmd_err_s;
  logic [1:0]  timing_err, timing_err_s;
  logic [15:0] err_cnt;
  logic [2:0]  err_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdr_modport_checker #(.BURST_LENGTH(BL), .TRAS(TRAS), .TRCD(TRCD), .TRP(TRP), .CNT_W(16)) u_dut (
    .sdram_clk(clk), .sdram_reset(rst), .sdr_init_done(init_done),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr),
    .bank_state(bank_state), .cmd_err(cmd_err), .timing_err(timing_err), .err_cnt(err_cnt));

  sdr_modport_checker #(.BURST_LENGTH(BL), .TRAS(TRAS), .TRCD(TRCD), .TRP(TRP), .CNT_W(3)) u_dut_sat (
    .sdram_clk(clk), .sdram_reset(rst), .sdr_init_done(init_done),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr),
    .bank_state(bank_state_s), .cmd_err(cmd_err_s), .timing_err(timing_err_s), .err_cnt(err_cnt_s));

  // ---------------- behavioural model ----------------
  int       m_st[4]   = '{default: 0};
  int       m_cnt[4]  = '{default: 0};
  int       m_age[4]  = '{default: 0};
  bit       m_av[4]   = '{default: 0};
  bit [3:0] m_cerr    = '0;
  bit [1:0] m_terr    = '0;
  int       m_ec16    = 0;
  int       m_ec3     = 0;

  function automatic int sat_add(int a, int inc, int lim);
    return (a + inc > lim) ? lim : a + inc;
  endfunction

  function automatic bit legal(int st, cmd_t c);
    if (c == NOP) return 1'b1;
    case (st)
      S_IDLE:     return c inside {ACT, AREF, LMR, PRE};
      S_ACTIVE:   return c inside {READ, WRITE, PRE};
      S_RD, S_WR: return c inside {READ, WRITE, PRE, BST};
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_bank_state();
    logic [15:0] v;
    for (int b = 0; b < 4; b++) v[4*b +: 4] = 4'(m_st[b]);
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_st[b] = S_INIT; m_cnt[b] = 0; m_age[b] = 0; m_av[b] = 1'b0;
    end
    m_cerr = '0; m_terr = '0; m_ec16 = 0; m_ec3 = 0;
  endtask

  task automatic model_step();
    cmd_t     c;
    bit [3:0] ncerr;
    bit [1:0] nterr;
    int       inc;
    c     = cs_n ? NOP : cmd_t'({ras_n, cas_n, we_n});
    ncerr = '0;
    nterr = '0;
    inc    = $countones(m_cerr) + $countones(m_terr);
    m_ec16 = sat_add(m_ec16, inc, 65535);
    m_ec3  = sat_add(m_ec3, inc, 7);
    for (int b = 0; b < 4; b++) begin
      bit tgt, restart;
      int st, ns, done;
      tgt  = (int'(ba) == b) || (c == PRE && addr[10]);
      st   = m_st[b];
      ns   = st;
      done = m_cnt[b] + 1;  // clocks spent in the current state, this one included
      if (tgt && st != S_INIT && !legal(st, c)) ncerr[b] = 1'b1;
      if (TEN && m_av[b] && tgt) begin
        if (c == PRE && m_age[b] < TRAS) nterr[0] = 1'b1;
        if ((c == READ || c == WRITE) && m_age[b] < TRCD) nterr[1] = 1'b1;
      end
      case (st)
        S_INIT:       if (init_done) ns = S_IDLE;
        S_IDLE:       if (tgt && c == ACT) ns = S_ACTIVATING;
                      else if (tgt && c == AREF) ns = S_REFRESH;
        S_REFRESH:    ns = S_IDLE;
        S_ACTIVATING: if (done >= TRCD) ns = S_ACTIVE;
        S_ACTIVE:     if (tgt && c == WRITE) ns = addr[10] ? S_WR_AP : S_WR;
                      else if (tgt && c == READ) ns = addr[10] ? S_RD_AP : S_RD;
                      else if (tgt && c == PRE) ns = S_PRECHARGING;
        S_RD, S_WR:   if (tgt && c == WRITE) ns = S_WR;
                      else if (tgt && c == READ) ns = S_RD;
                      else if (tgt && c == PRE) ns = S_PRECHARGING;
                      else if ((tgt && c == BST) || done >= BL) ns = S_ACTIVE;
        S_RD_AP, S_WR_AP: if (done >= BL) ns = S_PRECHARGING;
        S_PRECHARGING:    if (done >= TRP) ns = S_IDLE;
        default:          ns = st;
      endcase
      restart  = tgt && (c == READ || c == WRITE) && (st == S_RD || st == S_WR);
      m_cnt[b] = (ns != st || restart) ? 0 : m_cnt[b] + 1;
      m_st[b]  = ns;
      if (c == ACT && int'(ba) == b) begin
        m_age[b] = 0;
        m_av[b]  = 1'b1;
      end else if (m_age[b] < AGE_MAX) begin
        m_age[b] = m_age[b] + 1;
      end
    end
    m_cerr = ncerr;
    m_terr = nterr;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_bank_state", 32'(bank_state), 32'(m_bank_state()));
    chk("model_cmd_err", 32'(cmd_err), 32'(m_cerr));
    chk("model_timing_err", 32'(timing_err), 32'(m_terr));
    chk("model_err_cnt", 32'(err_cnt), 32'(m_ec16));
    chk("model_err_cnt_sat", 32'(err_cnt_s), 32'(m_ec3));
    chk("model_bank_state_sat", 32'(bank_state_s), 32'(m_bank_state()));
  end

  // ---------------- stimulus ----------------
  task automatic drive(cmd_t c, int b, bit a10);
    ba   = 2'(b);
    addr = 13'($urandom);
    addr[10] = a10;
    if (c == NOP && $urandom_range(0, 1) == 1) begin
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = 3'($urandom);
    end else begin
      cs_n = 1'b0;
      {ras_n, cas_n, we_n} = c;
    end
  endtask

  task automatic step(cmd_t c, int b, bit a10);
    drive(c, b, a10);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  cmd_t seq_rd[8]  = '{ACT, NOP, NOP, READ, NOP, NOP, NOP, NOP};
  int   exp_rd[8]  = '{3, 3, 4, 5, 5, 5, 5, 4};
  int   exp_wap[6] = '{8, 8, 9, 9, 9, 1};

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_bank_state", 32'(bank_state), 32'h0000);
    chk("reset_err_cnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    step(NOP, 0, 1'b0);
    chk("init_hold", 32'(bank_state), 32'h0000);
    init_done = 1'b1;
    step(NOP, 0, 1'b0);
    chk("init_to_idle", 32'(bank_state), 32'h1111);

    for (int i = 0; i < 8; i++) begin
      step(seq_rd[i], 1, 1'b0);
      chk("bank1_read_seq", 32'(bank_state[7:4]), 32'(exp_rd[i]));
    end
    chk("bank1_read_no_err", 32'(err_cnt), 32'h0);

    step(ACT, 2, 1'b0);
    step(READ, 2, 1'b0);
    chk("early_read_cmd_err", 32'(cmd_err), 32'h4);
    chk("early_read_trcd", 32'(timing_err), 32'({TEN, 1'b0}));
    step(NOP, 0, 1'b0);
    chk("early_read_err_cnt", 32'(err_cnt), 32'(1 + int'(TEN)));

    step(ACT, 3, 1'b0);
    step(NOP, 0, 1'b0);
    step(NOP, 0, 1'b0);
    step(PRE, 3, 1'b0);
    chk("tras_pre_state", 32'(bank_state[15:12]), 32'd9);
    chk("tras_flag", 32'(timing_err), 32'({1'b0, TEN}));
    step(NOP, 0, 1'b0);
    chk("tras_flag_one_clock", 32'(timing_err), 32'h0);
    for (int i = 0; i < 3; i++) step(NOP, 0, 1'b0);

    step(PRE, 0, 1'b1);
    chk("pre_all_enter", 32'(bank_state), 32'h1991);
    step(NOP, 0, 1'b0);
    step(NOP, 0, 1'b0);
    chk("pre_all_hold", 32'(bank_state), 32'h1991);
    step(NOP, 0, 1'b0);
    chk("pre_all_done", 32'(bank_state), 32'h1111);

    step(ACT, 0, 1'b0);
    step(NOP, 0, 1'b0);
    step(NOP, 0, 1'b0);
    step(WRITE, 0, 1'b1);
    chk("wr_ap_enter", 32'(bank_state[3:0]), 32'd8);
    step(READ, 0, 1'b0);
    chk("wr_ap_read_err", 32'(cmd_err), 32'h1);
    chk("wr_ap_read_state", 32'(bank_state[3:0]), 32'd8);
    for (int i = 0; i < 6; i++) begin
      step(NOP, 0, 1'b0);
      chk("wr_ap_seq", 32'(bank_state[3:0]), 32'(exp_wap[i]));
    end

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1;
        chk("async_reset_state", 32'(bank_state), 32'h0000);
        chk("async_reset_err", 32'(cmd_err), 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        init_done = 1'b0;
      end
      if (i == 1505) init_done = 1'b1;
      if ($urandom_range(0, 99) < 45) step(NOP, $urandom_range(0, 3), 1'($urandom));
      else step(cmd_t'(3'($urandom_range(0, 6))), $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
